// File: rtl/alu_seq_16bits.sv
// rtl/alu_seq_16bits.sv - 16-bit sequential ALU that walks 4 nibbles through an external 4-bit ALU core
module alu_seq_16bits (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [3:0]  OP,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        CI,
  output logic [3:0]  CORE_SEL,
  output logic [3:0]  CORE_A,
  output logic [3:0]  CORE_B,
  output logic        CORE_CI,
  input  logic [3:0]  CORE_R,
  input  logic        CORE_CO,
  input  logic        CORE_OV,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] R,
  output logic        CO,
  output logic        OV,
  output logic        Z,
  output logic        S
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  r_n;
  logic [3:0]  r_op;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic        r_ci;
  logic        r_carry;
  logic [11:0] r_acc;
  logic [15:0] r_r;
  logic        r_co;
  logic        r_ov;
  logic        r_z;
  logic        r_s;

  logic [3:0]  w_a_nib;
  logic [3:0]  w_b_nib;
  logic [15:0] w_res;

  always_comb begin
    w_a_nib = 4'h0;
    w_b_nib = 4'h0;
    case (r_n)
      2'd0: begin w_a_nib = r_a[3:0];   w_b_nib = r_b[3:0];   end
      2'd1: begin w_a_nib = r_a[7:4];   w_b_nib = r_b[7:4];   end
      2'd2: begin w_a_nib = r_a[11:8];  w_b_nib = r_b[11:8];  end
      default: begin w_a_nib = r_a[15:12]; w_b_nib = r_b[15:12]; end
    endcase
  end

  // ADD/SUB become their carry-chained forms above the least significant nibble
  always_comb begin
    CORE_SEL = 4'h0;
    CORE_A   = 4'h0;
    CORE_B   = 4'h0;
    CORE_CI  = 1'b0;
    if (r_state == ST_RUN) begin
      CORE_A  = w_a_nib;
      CORE_B  = w_b_nib;
      CORE_CI = (r_n == 2'd0) ? r_ci : r_carry;
      case (r_op[2:0])
        3'b000:  CORE_SEL = (r_n == 2'd0) ? r_op : {r_op[3], 3'b010};
        3'b001:  CORE_SEL = (r_n == 2'd0) ? r_op : {r_op[3], 3'b011};
        default: CORE_SEL = r_op;
      endcase
    end
  end

  assign w_res = {CORE_R, r_acc};

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_n     <= 2'd0;
      r_op    <= 4'h0;
      r_a     <= 16'h0000;
      r_b     <= 16'h0000;
      r_ci    <= 1'b0;
      r_carry <= 1'b0;
      r_acc   <= 12'h000;
      r_r     <= 16'h0000;
      r_co    <= 1'b0;
      r_ov    <= 1'b0;
      r_z     <= 1'b0;
      r_s     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            r_op    <= OP;
            r_a     <= A;
            r_b     <= B;
            r_ci    <= CI;
            r_n     <= 2'd0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_carry <= CORE_CO;
          r_n     <= r_n + 2'd1;
          case (r_n)
            2'd0: r_acc[3:0]  <= CORE_R;
            2'd1: r_acc[7:4]  <= CORE_R;
            2'd2: r_acc[11:8] <= CORE_R;
            default: begin
              r_r     <= w_res;
              r_co    <= CORE_CO;
              r_ov    <= CORE_OV;
              r_z     <= (w_res == 16'h0000);
              r_s     <= CORE_R[3] ^ CORE_OV;
              r_state <= ST_FIN;
            end
          endcase
        end
        ST_FIN:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign BUSY = (r_state == ST_RUN);
  assign DONE = (r_state == ST_FIN);
  assign R    = r_r;
  assign CO   = r_co;
  assign OV   = r_ov;
  assign Z    = r_z;
  assign S    = r_s;

endmodule

// File: tb/tb_alu_seq_16bits.sv
// tb/tb_alu_seq_16bits.sv - self-checking bench for alu_seq_16bits with a behavioural 4-bit core
module tb_alu_seq_16bits;

  logic        CLK = 1'b0;
  logic        RST, START, CI;
  logic [3:0]  OP;
  logic [15:0] A, B;
  logic [3:0]  CORE_SEL, CORE_A, CORE_B, CORE_R;
  logic        CORE_CI, CORE_CO, CORE_OV;
  logic        BUSY, DONE, CO, OV, Z, S;
  logic [15:0] R;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] ci_trace;

  alu_seq_16bits dut (
    .CLK(CLK), .RST(RST), .START(START), .OP(OP), .A(A), .B(B), .CI(CI),
    .CORE_SEL(CORE_SEL), .CORE_A(CORE_A), .CORE_B(CORE_B), .CORE_CI(CORE_CI),
    .CORE_R(CORE_R), .CORE_CO(CORE_CO), .CORE_OV(CORE_OV),
    .BUSY(BUSY), .DONE(DONE), .R(R), .CO(CO), .OV(OV), .Z(Z), .S(S)
  );

  always #5 CLK = ~CLK;

  // 4-bit core: x000 ADD, x001 SUB, x010 ADC, x011 SBC, x100 AND, x101 OR, x110 XOR, x111 NOT B; bit3 inverts AND/OR/XOR
  logic [4:0] m_t;
  always_comb begin
    m_t     = 5'h00;
    CORE_R  = 4'h0;
    CORE_CO = 1'b0;
    CORE_OV = 1'b0;
    case (CORE_SEL[2:0])
      3'b000, 3'b010: begin
        m_t = 5'(CORE_A) + 5'(CORE_B) + ((CORE_SEL[1]) ? 5'(CORE_CI) : 5'd0);
        CORE_R  = m_t[3:0];
        CORE_CO = m_t[4];
        CORE_OV = (CORE_A[3] == CORE_B[3]) && (m_t[3] != CORE_A[3]);
      end
      3'b001, 3'b011: begin
        m_t = 5'(CORE_A) - 5'(CORE_B) - ((CORE_SEL[1]) ? 5'(CORE_CI) : 5'd0);
        CORE_R  = m_t[3:0];
        CORE_CO = m_t[4];
        CORE_OV = (CORE_A[3] != CORE_B[3]) && (m_t[3] != CORE_A[3]);
      end
      3'b100:  CORE_R = CORE_SEL[3] ? ~(CORE_A & CORE_B) : (CORE_A & CORE_B);
      3'b101:  CORE_R = CORE_SEL[3] ? ~(CORE_A | CORE_B) : (CORE_A | CORE_B);
      3'b110:  CORE_R = CORE_SEL[3] ? ~(CORE_A ^ CORE_B) : (CORE_A ^ CORE_B);
      default: begin CORE_R = ~CORE_B; CORE_CO = 1'b1; end
    endcase
  end

  typedef struct packed {
    logic [15:0] r;
    logic co, ov, z, s;
  } res_t;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b;
    logic        ci;
    res_t        exp;
  } vec_t;

  // Whole-word reference: 16-bit arithmetic and signed-overflow rules
  function automatic res_t ref_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                     input logic ci);
    logic [16:0] w;
    res_t x;
    x = '0;
    w = '0;
    case (op[2:0])
      3'b000:  w = 17'(a) + 17'(b);
      3'b010:  w = 17'(a) + 17'(b) + 17'(ci);
      3'b001:  w = 17'(a) - 17'(b);
      3'b011:  w = 17'(a) - 17'(b) - 17'(ci);
      3'b100:  w = {1'b0, op[3] ? ~(a & b) : (a & b)};
      3'b101:  w = {1'b0, op[3] ? ~(a | b) : (a | b)};
      3'b110:  w = {1'b0, op[3] ? ~(a ^ b) : (a ^ b)};
      default: w = {1'b1, ~b};
    endcase
    x.r  = w[15:0];
    x.co = w[16];
    if (op[2] == 1'b0)
      x.ov = op[0] ? ((a[15] != b[15]) && (w[15] != a[15])) : ((a[15] == b[15]) && (w[15] != a[15]));
    x.z = (x.r == 16'h0000);
    x.s = x.r[15] ^ x.ov;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic ci,
                        input bit scramble, input res_t exp, input string name);
    int   cycles;
    logic busy_ok;
    OP = op; A = a; B = b; CI = ci; START = 1'b1;
    tick();
    START = 1'b0;
    cycles = 1;
    busy_ok = BUSY;
    ci_trace = 4'h0;
    ci_trace[0] = CORE_CI;
    if (scramble) begin
      OP = 4'($urandom); A = 16'($urandom); B = 16'($urandom); CI = 1'($urandom);
    end
    while (!DONE && cycles < 12) begin
      tick();
      cycles++;
      if (!DONE && cycles <= 4) begin
        ci_trace[cycles-1] = CORE_CI;
        if (!BUSY) busy_ok = 1'b0;
      end
    end
    check({name, " latency"}, cycles, 5);
    check({name, " busy_run"}, busy_ok, 1);
    check({name, " busy_fin"}, BUSY, 0);
    check({name, " R"}, R, exp.r);
    check({name, " CO/OV/Z/S"}, {CO, OV, Z, S}, {exp.co, exp.ov, exp.z, exp.s});
    check({name, " core_idle"}, {CORE_SEL, CORE_A, CORE_B, CORE_CI}, 0);
    tick();
    check({name, " done_pulse"}, DONE, 0);
    check({name, " R_held"}, R, exp.r);
  endtask

  vec_t vecs[9];

  initial begin
    int   done_cnt, first_done;
    logic busy_fin, busy7;
    res_t e;

    vecs[0] = '{4'b0000, 16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[1] = '{4'b0001, 16'h0000, 16'h0001, 1'b0, '{16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1}};
    vecs[2] = '{4'b0010, 16'hFFFF, 16'h0000, 1'b1, '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[3] = '{4'b0110, 16'hA5A5, 16'hA5A5, 1'b0, '{16'h0000, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[4] = '{4'b0111, 16'hA5A5, 16'h00FF, 1'b0, '{16'hFF00, 1'b1, 1'b0, 1'b0, 1'b1}};
    vecs[5] = '{4'b0011, 16'h0000, 16'h0000, 1'b1, '{16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1}};
    vecs[6] = '{4'b0100, 16'hF0F0, 16'hFF00, 1'b0, '{16'hF000, 1'b0, 1'b0, 1'b0, 1'b1}};
    vecs[7] = '{4'b1100, 16'hFFFF, 16'hFFFF, 1'b0, '{16'h0000, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[8] = '{4'b0001, 16'h8000, 16'h0001, 1'b0, '{16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b1}};

    RST = 1'b1; START = 1'b0; OP = 4'h0; A = 16'h0; B = 16'h0; CI = 1'b0;
    tick(); tick();
    check("reset_outputs", {BUSY, DONE, R, CO, OV, Z, S}, 0);
    check("reset_core", {CORE_SEL, CORE_A, CORE_B, CORE_CI}, 0);
    START = 1'b1; OP = 4'h0; A = 16'h1234;
    tick();
    check("reset_over_start", BUSY, 0);
    START = 1'b0; RST = 1'b0;
    tick();

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ci, i[0], vecs[i].exp, $sformatf("vec%0d", i));

    run_op(4'b0010, 16'hFFFF, 16'h0000, 1'b1, 1'b0, vecs[2].exp, "adc_ci");
    check("adc_ci_chain", ci_trace, 4'b1111);

    // START held: one completion, then immediate re-acceptance after FIN
    OP = 4'b0000; A = 16'h1111; B = 16'h2222; CI = 1'b0; START = 1'b1;
    done_cnt = 0; first_done = 0; busy_fin = 1'b0; busy7 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (DONE) begin
        done_cnt++;
        if (first_done == 0) first_done = k;
        if (BUSY) busy_fin = 1'b1;
      end
      if (k == 7) busy7 = BUSY;
    end
    START = 1'b0;
    check("held_done_count", done_cnt, 1);
    check("held_done_cycle", first_done, 5);
    check("held_busy_in_fin", busy_fin, 0);
    check("held_reaccept", busy7, 1);
    for (int k = 0; k < 8 && !DONE; k++) tick();
    check("held_second_done", DONE, 1);
    check("held_second_R", R, 16'h3333);
    tick();

    // Abort mid-RUN after a completed op left nonzero results
    run_op(vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].ci, 1'b0, vecs[0].exp, "pre_abort");
    OP = 4'b0001; A = 16'h0005; B = 16'h0003; START = 1'b1;
    tick();
    START = 1'b0;
    tick(); tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("abort_busy", BUSY, 0);
    check("abort_R", R, 16'h0000);
    check("abort_flags", {DONE, CO, OV, Z, S}, 0);
    done_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (DONE) done_cnt++;
      tick();
    end
    check("abort_no_done", done_cnt, 0);
    run_op(4'b0001, 16'h0005, 16'h0003, 1'b0, 1'b0, ref_model(4'b0001, 16'h0005, 16'h0003, 1'b0), "after_abort");

    for (int i = 0; i < 40; i++) begin
      logic [3:0]  op;
      logic [15:0] a, b;
      logic        ci;
      op = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      b  = 16'($urandom);
      ci = 1'($urandom);
      e  = ref_model(op, a, b, ci);
      run_op(op, a, b, ci, 1'b1, e, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_16bits.md
ALU_SEQ_16BITS -- requirements
Module: alu_seq_16bits

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 16 bits, processed as 4 nibbles through one external 4-bit ALU core (alu_core_4bits).
REQ-002 CLK  input  1  single clock, all state on rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 START  input  1  request; accepted only in IDLE.
REQ-005 OP  input  4  operation code, same SEL encoding as alu_core_4bits.
REQ-006 A  input  16  operand A.
REQ-007 B  input  16  operand B.
REQ-008 CI  input  1  external carry/borrow in.
REQ-009 CORE_SEL  output  4  SEL driven to core.
REQ-010 CORE_A  output  4  nibble of A driven to core.
REQ-011 CORE_B  output  4  nibble of B driven to core.
REQ-012 CORE_CI  output  1  CI driven to core.
REQ-013 CORE_R  input  4  core result.
REQ-014 CORE_CO  input  1  core carry/borrow out.
REQ-015 CORE_OV  input  1  core overflow.
REQ-016 BUSY  output  1  high in RUN.
REQ-017 DONE  output  1  one-cycle pulse, results valid.
REQ-018 R  output  16  result, held until next completion.
REQ-019 CO  output  1  final carry/borrow.
REQ-020 OV  output  1  final overflow.
REQ-021 Z  output  1  1 when R == 16'h0000.
REQ-022 S  output  1  R[15] XOR OV.

Function
REQ-023 States SHALL be IDLE, RUN, FIN; nibble counter N is 2 bits.
REQ-024 IDLE & START: latch OP, A, B, CI; N=0; go to RUN. START without transition is ignored in RUN and FIN.
REQ-025 RUN: drive CORE_A=A[4N+3:4N], CORE_B=B[4N+3:4N]; at cycle end capture CORE_R into accumulator nibble N, CORE_CO into carry reg, CORE_OV into ov reg; N increments; after N=3 go to FIN.
REQ-026 CORE_SEL per nibble: OP=x000 -> x000 on N=0, x010 on N>0; OP=x001 -> x001 on N=0, x011 on N>0; all other OP -> OP unchanged on every nibble.
REQ-027 CORE_CI: N=0 -> latched CI; N>0 -> carry reg (carry/borrow from previous nibble).
REQ-028 Logic ops (AND/OR/XOR/NAND/NOR/XNOR) SHALL pass core CO=0; NOT (x111) passes core CO=1; no special-casing in this block.
REQ-029 At the N=3 capture, R, CO, OV load from the completed accumulator and MS-nibble CO/OV; Z and S are registered from the same values.
REQ-030 FIN: DONE=1 for exactly one cycle, BUSY=0; next state IDLE. START in FIN is ignored.
REQ-031 Latency: START accepted at edge t -> RUN cycles t+1..t+4 -> DONE high in cycle t+5; back-to-back throughput one op per 6 cycles.
REQ-032 Outside RUN, CORE_SEL, CORE_A, CORE_B, CORE_CI SHALL be 0.
REQ-033 Latched operands SHALL not change during RUN regardless of A/B/OP/CI inputs.

Reset
REQ-034 RST high at an edge SHALL force IDLE, N=0, and BUSY=0, DONE=0, R=0, CO=0, OV=0, Z=0, S=0, internal regs 0; RST has priority over START.
REQ-035 RST mid-RUN SHALL abort the operation with no DONE and prior results cleared.

Verification
REQ-036 OP=0000, A=7FFF, B=0001 -> DONE at t+5, R=8000, CO=0, OV=1, Z=0, S=0.
REQ-037 OP=0001, A=0000, B=0001 -> R=FFFF, CO=1, OV=0, Z=0, S=1.
REQ-038 OP=0010, CI=1, A=FFFF, B=0000 -> R=0000, CO=1, OV=0, Z=1; CORE_CI=1 on all four nibbles.
REQ-039 OP=0110, A=B=A5A5 -> R=0000, Z=1, CO=0; then OP=0111, B=00FF -> R=FF00, CO=1, OV=0, S=1.
REQ-040 START held high for 10 cycles -> exactly one DONE at t+5, then new op accepted at t+6 edge, BUSY never asserted in FIN.
REQ-041 RST asserted during third RUN cycle -> next cycle BUSY=0, R=0000, no DONE pulse; fresh START afterwards completes normally.
